// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event payload for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam int unsigned EVENT_W = 10;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam logic [7:0] SC_SYS_00    = 8'h00;
  localparam logic [7:0] SC_BAT_OK    = 8'hAA;
  localparam logic [7:0] SC_ECHO      = 8'hEE;
  localparam logic [7:0] SC_ACK       = 8'hFA;
  localparam logic [7:0] SC_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] SC_DIAG_FAIL = 8'hFD;
  localparam logic [7:0] SC_RESEND    = 8'hFE;
  localparam logic [7:0] SC_ERROR     = 8'hFF;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GOT_E0   = 3'd1,
    ST_GOT_F0   = 3'd2,
    ST_GOT_E0F0 = 3'd3,
    ST_PAUSE    = 3'd4
  } state_t;

  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] code;
  } event_t;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic ralt;
  } mods_t;

  function automatic logic is_system(input logic [7:0] b);
    return b inside {SC_SYS_00, SC_BAT_OK, SC_ECHO, SC_ACK,
                     SC_BAT_FAIL, SC_DIAG_FAIL, SC_RESEND, SC_ERROR};
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return b inside {SC_EXT, SC_BREAK, SC_PAUSE};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO; head holds the last popped word while empty.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (!empty)  last_q <= mem[rd_ptr];
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: folds E0/F0 prefixes into key events, swallows Pause
// and system bytes, queues events and tracks modifier state.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PAUSE_TAIL = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          valid_data,
  input  logic [7:0]                    data,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [7:0]                    event_code,
  output logic                          event_break,
  output logic                          event_extended,
  output logic                          shift_held,
  output logic                          ctrl_held,
  output logic                          alt_held,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = (PAUSE_TAIL < 2) ? 1 : $clog2(PAUSE_TAIL + 1);

  state_t         state;
  state_t         state_next;
  logic [PW-1:0]  pause_cnt;
  logic           emit;
  logic           load_pause;
  event_t         ev;
  event_t         head;
  mods_t          mods_q;
  mods_t          mods_d;
  logic           fifo_full;
  logic           fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state: system bytes abort any prefix; redundant prefixes are ignored.
  always_comb begin
    state_next = state;
    if (valid_data) begin
      case (state)
        ST_IDLE: begin
          if (is_system(data))        state_next = ST_IDLE;
          else if (data == SC_EXT)    state_next = ST_GOT_E0;
          else if (data == SC_BREAK)  state_next = ST_GOT_F0;
          else if (data == SC_PAUSE)  state_next = (PAUSE_TAIL == 0) ? ST_IDLE : ST_PAUSE;
          else                        state_next = ST_IDLE;
        end
        ST_GOT_E0: begin
          if (is_system(data))        state_next = ST_IDLE;
          else if (data == SC_BREAK)  state_next = ST_GOT_E0F0;
          else if (is_prefix(data))   state_next = ST_GOT_E0;
          else                        state_next = ST_IDLE;
        end
        ST_GOT_F0, ST_GOT_E0F0: begin
          if (is_system(data))        state_next = ST_IDLE;
          else if (is_prefix(data))   state_next = state;
          else                        state_next = ST_IDLE;
        end
        ST_PAUSE: begin
          if (pause_cnt <= PW'(1))    state_next = ST_IDLE;
        end
        default:                      state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    emit        = 1'b0;
    load_pause  = 1'b0;
    ev          = '0;
    ev.code     = data;
    ev.extended = (state == ST_GOT_E0) || (state == ST_GOT_E0F0);
    ev.brk      = (state == ST_GOT_F0) || (state == ST_GOT_E0F0);
    if (valid_data) begin
      emit = (state inside {ST_IDLE, ST_GOT_E0, ST_GOT_F0, ST_GOT_E0F0})
             && !is_system(data) && !is_prefix(data);
      load_pause = (state == ST_IDLE) && (data == SC_PAUSE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                                              pause_cnt <= '0;
    else if (load_pause)                                    pause_cnt <= PW'(PAUSE_TAIL);
    else if (valid_data && state == ST_PAUSE && pause_cnt != '0) pause_cnt <= pause_cnt - PW'(1);
  end

  // Modifiers follow every decoded event, even one the FIFO drops.
  always_comb begin
    mods_d = mods_q;
    if (emit) begin
      if (!ev.extended) begin
        case (ev.code)
          SC_LSHIFT: mods_d.lshift = !ev.brk;
          SC_RSHIFT: mods_d.rshift = !ev.brk;
          SC_CTRL:   mods_d.lctrl  = !ev.brk;
          SC_ALT:    mods_d.lalt   = !ev.brk;
          default:   ;
        endcase
      end else begin
        case (ev.code)
          SC_CTRL:   mods_d.rctrl  = !ev.brk;
          SC_ALT:    mods_d.ralt   = !ev.brk;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mods_q     <= '0;
      shift_held <= 1'b0;
      ctrl_held  <= 1'b0;
      alt_held   <= 1'b0;
    end else begin
      mods_q     <= mods_d;
      shift_held <= mods_d.lshift | mods_d.rshift;
      ctrl_held  <= mods_d.lctrl  | mods_d.rctrl;
      alt_held   <= mods_d.lalt   | mods_d.ralt;
    end
  end

  // A new drop outranks a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset)                                              overflow <= 1'b0;
    else if (emit && fifo_full && !(event_ready && event_valid)) overflow <= 1'b1;
    else if (clear_overflow)                                overflow <= 1'b0;
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (emit),
    .pop   (event_ready),
    .wdata (ev),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign event_valid    = !fifo_empty;
  assign event_code     = head.code;
  assign event_break    = head.brk;
  assign event_extended = head.extended;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a queue scoreboard and pop monitor.
module tb_ps2_scancode_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid_data = 1'b0;
  logic [7:0] data = 8'h00;
  logic       event_valid;
  logic       event_ready = 1'b0;
  logic [7:0] event_code;
  logic       event_break;
  logic       event_extended;
  logic       shift_held;
  logic       ctrl_held;
  logic       alt_held;
  logic       overflow;
  logic       clear_overflow = 1'b0;
  logic [3:0] fifo_count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [9:0]  exp_q [$];

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .PAUSE_TAIL(7)) dut (
    .clock          (clock),
    .reset          (reset),
    .valid_data     (valid_data),
    .data           (data),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_code     (event_code),
    .event_break    (event_break),
    .event_extended (event_extended),
    .shift_held     (shift_held),
    .ctrl_held      (ctrl_held),
    .alt_held       (alt_held),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .fifo_count     (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called aligned #1 after a rising edge; returns #1 after the sampling edge.
  task automatic send(input logic [7:0] b);
    valid_data = 1'b1;
    data       = b;
    @(posedge clock); #1;
    valid_data = 1'b0;
    data       = 8'h00;
  endtask

  task automatic exp_ev(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((fifo_count != 4'd0 || exp_q.size() != 0) && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_drain_count"}, 32'(fifo_count), 32'd0);
    chk({name, "_drain_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_valid"}, 32'(event_valid), 32'd0);
    chk({name, "_out"}, 32'({event_extended, event_break, event_code}), 32'd0);
    chk({name, "_held"}, 32'({shift_held, ctrl_held, alt_held}), 32'd0);
    chk({name, "_ovf"}, 32'(overflow), 32'd0);
    chk({name, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  // Scoreboard monitor: a pop happens on the rising edge after this sample.
  always @(negedge clock) begin
    if (!reset && event_valid && event_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %0h expected none",
                 {event_extended, event_break, event_code});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({event_extended, event_break, event_code} !== e) begin
          errors++;
          $display("FAIL event: got %0h expected %0h",
                   {event_extended, event_break, event_code}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    #0 reset = 1'b0;
    chk_reset_state("reset");

    // 1: single make, one-cycle latency, popped
    event_ready = 1'b1;
    send(8'h15); exp_ev(1'b0, 1'b0, 8'h15);
    chk("t1_valid", 32'(event_valid), 32'd1);
    chk("t1_count", 32'(fifo_count), 32'd1);
    idle(1);
    chk("t1_popped", 32'(fifo_count), 32'd0);

    // 2: plain makes including F1 and AB, then a break
    send(8'hF1); exp_ev(1'b0, 1'b0, 8'hF1);
    send(8'h15); exp_ev(1'b0, 1'b0, 8'h15);
    send(8'h35); exp_ev(1'b0, 1'b0, 8'h35);
    send(8'hAB); exp_ev(1'b0, 1'b0, 8'hAB);
    send(8'hF0);
    send(8'h15); exp_ev(1'b0, 1'b1, 8'h15);
    wait_drain("t2");

    // 3: modifiers
    send(8'h12); exp_ev(1'b0, 1'b0, 8'h12);
    send(8'hE0);
    send(8'h14); exp_ev(1'b1, 1'b0, 8'h14);
    send(8'hE0);
    send(8'h11); exp_ev(1'b1, 1'b0, 8'h11);
    chk("t3_held_all", 32'({shift_held, ctrl_held, alt_held}), 32'h7);
    send(8'hE0);
    send(8'hF0);
    send(8'h14); exp_ev(1'b1, 1'b1, 8'h14);
    chk("t3_ctrl_up", 32'(ctrl_held), 32'd0);
    send(8'h59); exp_ev(1'b0, 1'b0, 8'h59);
    send(8'hF0);
    send(8'h12); exp_ev(1'b0, 1'b1, 8'h12);
    chk("t3_shift_r", 32'({shift_held, ctrl_held, alt_held}), 32'h5);
    wait_drain("t3");

    // 4: Pause sequence is swallowed whole
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("t4_no_event", 32'(fifo_count), 32'd0);
    send(8'h35); exp_ev(1'b0, 1'b0, 8'h35);
    wait_drain("t4");
    chk("t4_held", 32'({shift_held, ctrl_held, alt_held}), 32'h5);

    // 5: overflow on full FIFO, drain, clear
    event_ready = 1'b0;
    repeat (8) begin send(8'h1C); exp_ev(1'b0, 1'b0, 8'h1C); end
    chk("t5_no_ovf_yet", 32'(overflow), 32'd0);
    send(8'h1C);
    chk("t5_count", 32'(fifo_count), 32'd8);
    chk("t5_ovf", 32'(overflow), 32'd1);
    event_ready = 1'b1;
    wait_drain("t5");
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);
    chk("t5_hold_head", 32'(event_code), 32'h1C);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    chk("t5_ovf_clr", 32'(overflow), 32'd0);

    // 6: system byte aborts prefix; reset abandons a pending break
    send(8'hE0);
    send(8'hAA);
    send(8'h35); exp_ev(1'b0, 1'b0, 8'h35);
    wait_drain("t6a");
    send(8'hF0);
    pulse_reset();
    chk_reset_state("t6_reset");
    send(8'h15); exp_ev(1'b0, 1'b0, 8'h15);
    wait_drain("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
